if_id_stage_register: RTL and testbench
=======================================

// Module: if_id_stage_register
// PURPOSE
// - IF/ID pipeline register of the 5-stage CPU. It sits directly downstream of the program counter
//   and instruction memory, and feeds the decode stage.
// - Captures PC+4 and the fetched instruction each cycle. Holds them on a hazard stall.
// - Inserts NOP bubbles on a branch/jump flush, and squashes wrong-path fetches for a
//   configurable depth.
// PARAMETERS
// - FLUSH_DEPTH  1   fetched instructions discarded per flush (legal range 1..4; 2 = branch resolved in EX)
// - CNT_W        16  width of the performance counters
// PORTS
// - Clk            in   1      clock; all state updates on posedge
// - Reset          in   1      synchronous, active-high reset
// - IfIdStall      in   1      hazard stall: hold contents (same cycle as PC stall)
// - IfIdFlush      in   1      control-transfer taken: squash the fetched instruction
// - ValidIn        in   1      fetch output is a real instruction
// - PCPlus4In      in   32     PC+4 of the fetched instruction
// - InstructionIn  in   32     instruction-memory read data
// - PCPlus4Out     out  32     registered PC+4 to ID
// - InstructionOut out  32     registered instruction to ID (NOP = 32'h0000_0000)
// - ValidOut       out  1      InstructionOut is a real instruction
// - SquashActive   out  1      squash counter nonzero (next unstalled load is a bubble)
// - StallCount     out  CNT_W  stall-cycle counter (see CONFIGURATION)
// - FlushCount     out  CNT_W  flush-cycle counter (see CONFIGURATION)
// BEHAVIOUR
// - One clock (Clk). Reset is synchronous and active-high (Reset).
// - Reset values: PCPlus4Out=0, InstructionOut=0, ValidOut=0, squash counter=0, SquashActive=0,
//   StallCount=0, FlushCount=0.
// - Latency: 1 cycle from inputs to outputs.
// - Priority at each posedge: Reset > IfIdFlush > IfIdStall > squash > normal load.
// - Reset:
//   - Clears all state, including an in-progress squash.
// - Flush (IfIdFlush=1, overrides any stall):
//   - Load a bubble: InstructionOut=0, PCPlus4Out=0, ValidOut=0.
//   - Squash counter <= FLUSH_DEPTH-1.
//   - A flush during an active squash reloads the counter. Counts do not accumulate.
// - Stall (IfIdStall=1, IfIdFlush=0):
//   - All outputs and the squash counter hold their values.
// - Squash (no flush, no stall, counter>0):
//   - Load a bubble and decrement the counter. The inputs are ignored.
// - Normal load (no flush, no stall, counter=0):
//   - PCPlus4Out<=PCPlus4In and ValidOut<=ValidIn.
//   - InstructionOut<=InstructionIn when ValidIn=1, else 0.
// - Squash counter: 2 bits, never wraps. SquashActive = (counter!=0), combinational from the
//   counter. With FLUSH_DEPTH=1 the counter is always 0.
// - A bubble is the all-zero word with ValidOut=0. ID treats it as sll $0,$0,0.
// CONFIGURATION
// - Macro IFID_PERF_COUNT_EN.
// - Defined:
//   - StallCount += 1 each cycle with Reset=0, IfIdStall=1, IfIdFlush=0.
//   - FlushCount += 1 each cycle with Reset=0, IfIdFlush=1.
//   - Both counters saturate at all-ones and never wrap.
// - Undefined:
//   - Counter logic is not built. StallCount and FlushCount are tied to 0.
//   - All other behaviour is identical.
// TESTING
// - Reset=1 for 1 cycle with inputs 0x1234/0x8C010004 -> every output reads 0 after the edge.
// - Load PCPlus4In=0x4, InstructionIn=0x20020005, ValidIn=1 -> next cycle outputs 0x4/0x20020005/1.
// - Hold IfIdStall=1 for 3 cycles with changing inputs -> outputs stay 0x4/0x20020005/1;
//   StallCount=3 (macro on).
// - FLUSH_DEPTH=2: IfIdFlush=1 with IfIdStall=1 -> bubble, SquashActive=1; the next unstalled load
//   is a bubble, SquashActive=0; the following load passes the inputs.
// - FLUSH_DEPTH=2: assert Reset mid-squash -> counter=0; the next load passes the inputs unsquashed.
// - Macro on, CNT_W=2: 5 stall cycles -> StallCount=3 (saturated); macro off -> StallCount=0.

Source files
------------

// File: rtl/if_id_stage_register.sv
// IF/ID pipeline register: captures PC+4 and instruction, holds on stall, bubbles on flush/squash.
// Optional stall/flush performance counters are built when IFID_PERF_COUNT_EN is defined.
module if_id_stage_register #(
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             IfIdStall,
    input  logic             IfIdFlush,
    input  logic             ValidIn,
    input  logic [31:0]      PCPlus4In,
    input  logic [31:0]      InstructionIn,
    output logic [31:0]      PCPlus4Out,
    output logic [31:0]      InstructionOut,
    output logic             ValidOut,
    output logic             SquashActive,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    // The flushing instruction itself is the first bubble; the counter covers the remainder.
    localparam logic [1:0] SQUASH_RELOAD = 2'(FLUSH_DEPTH - 1);

    logic [1:0] squash_cnt;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            PCPlus4Out     <= 32'h0;
            InstructionOut <= 32'h0;
            ValidOut       <= 1'b0;
            squash_cnt     <= 2'd0;
        end else if (IfIdFlush) begin
            PCPlus4Out     <= 32'h0;
            InstructionOut <= 32'h0;
            ValidOut       <= 1'b0;
            squash_cnt     <= SQUASH_RELOAD;
        end else if (IfIdStall) begin
            PCPlus4Out     <= PCPlus4Out;
            InstructionOut <= InstructionOut;
            ValidOut       <= ValidOut;
            squash_cnt     <= squash_cnt;
        end else if (squash_cnt != 2'd0) begin
            PCPlus4Out     <= 32'h0;
            InstructionOut <= 32'h0;
            ValidOut       <= 1'b0;
            squash_cnt     <= squash_cnt - 2'd1;
        end else begin
            PCPlus4Out     <= PCPlus4In;
            InstructionOut <= ValidIn ? InstructionIn : 32'h0;
            ValidOut       <= ValidIn;
            squash_cnt     <= 2'd0;
        end
    end

    assign SquashActive = (squash_cnt != 2'd0);

`ifdef IFID_PERF_COUNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (IfIdStall && !IfIdFlush) begin
                StallCount <= sat_inc(StallCount);
            end
            if (IfIdFlush) begin
                FlushCount <= sat_inc(FlushCount);
            end
        end
    end
`else
    assign StallCount = '0;
    assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_if_id_stage_register.sv
// Directed bench for if_id_stage_register: one FLUSH_DEPTH=2/CNT_W=16 instance and one
// FLUSH_DEPTH=1/CNT_W=2 instance driven by the same stimulus.
module tb_if_id_stage_register;

    logic        Clk;
    logic        Reset;
    logic        IfIdStall;
    logic        IfIdFlush;
    logic        ValidIn;
    logic [31:0] PCPlus4In;
    logic [31:0] InstructionIn;

    logic [31:0] pc_a, ins_a, pc_b, ins_b;
    logic        vld_a, sq_a, vld_b, sq_b;
    logic [15:0] stall_cnt_a, flush_cnt_a;
    logic [1:0]  stall_cnt_b, flush_cnt_b;

    int n_vec = 0;
    int n_err = 0;

    if_id_stage_register #(.FLUSH_DEPTH(2), .CNT_W(16)) u_dut_a (
        .Clk(Clk), .Reset(Reset), .IfIdStall(IfIdStall), .IfIdFlush(IfIdFlush),
        .ValidIn(ValidIn), .PCPlus4In(PCPlus4In), .InstructionIn(InstructionIn),
        .PCPlus4Out(pc_a), .InstructionOut(ins_a), .ValidOut(vld_a),
        .SquashActive(sq_a), .StallCount(stall_cnt_a), .FlushCount(flush_cnt_a)
    );

    if_id_stage_register #(.FLUSH_DEPTH(1), .CNT_W(2)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .IfIdStall(IfIdStall), .IfIdFlush(IfIdFlush),
        .ValidIn(ValidIn), .PCPlus4In(PCPlus4In), .InstructionIn(InstructionIn),
        .PCPlus4Out(pc_b), .InstructionOut(ins_b), .ValidOut(vld_b),
        .SquashActive(sq_b), .StallCount(stall_cnt_b), .FlushCount(flush_cnt_b)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] perf(input int v);
`ifdef IFID_PERF_COUNT_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic v, input logic sq, input int sc, input int fc);
        chk({tag, ".a.pc"},    pc_a, pc);
        chk({tag, ".a.ins"},   ins_a, ins);
        chk({tag, ".a.vld"},   32'(vld_a), 32'(v));
        chk({tag, ".a.sq"},    32'(sq_a), 32'(sq));
        chk({tag, ".a.stall"}, 32'(stall_cnt_a), perf(sc));
        chk({tag, ".a.flush"}, 32'(flush_cnt_a), perf(fc));
    endtask

    task automatic chk_b(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic v, input int sc, input int fc);
        chk({tag, ".b.pc"},    pc_b, pc);
        chk({tag, ".b.ins"},   ins_b, ins);
        chk({tag, ".b.vld"},   32'(vld_b), 32'(v));
        chk({tag, ".b.sq"},    32'(sq_b), 32'd0);
        chk({tag, ".b.stall"}, 32'(stall_cnt_b), perf(sc));
        chk({tag, ".b.flush"}, 32'(flush_cnt_b), perf(fc));
    endtask

    task automatic drive(input logic rst, input logic stall, input logic flush,
                         input logic v, input logic [31:0] pc, input logic [31:0] ins);
        Reset         = rst;
        IfIdStall     = stall;
        IfIdFlush     = flush;
        ValidIn       = v;
        PCPlus4In     = pc;
        InstructionIn = ins;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; IfIdStall = 1'b0; IfIdFlush = 1'b0; ValidIn = 1'b0;
        PCPlus4In = 32'h0; InstructionIn = 32'h0;
        @(negedge Clk);

        // Reset with live inputs
        drive(1, 0, 0, 1, 32'h1234, 32'h8C010004);
        chk_a("reset", 32'h0, 32'h0, 0, 0, 0, 0);
        chk_b("reset", 32'h0, 32'h0, 0, 0, 0);

        // Normal load
        drive(0, 0, 0, 1, 32'h4, 32'h20020005);
        chk_a("load1", 32'h4, 32'h20020005, 1, 0, 0, 0);
        chk_b("load1", 32'h4, 32'h20020005, 1, 0, 0);

        // Five stall cycles with changing inputs
        for (int i = 1; i <= 5; i++) begin
            drive(0, 1, 0, 1, 32'h100 + 32'(i), 32'hA0000000 + 32'(i));
            chk_a("stall", 32'h4, 32'h20020005, 1, 0, i, 0);
            chk_b("stall", 32'h4, 32'h20020005, 1, (i > 3) ? 3 : i, 0);
        end

        // Invalid fetch zeroes the instruction
        drive(0, 0, 0, 0, 32'h10, 32'hDEADBEEF);
        chk_a("invalid", 32'h10, 32'h0, 0, 0, 5, 0);
        chk_b("invalid", 32'h10, 32'h0, 0, 3, 0);

        // Flush overrides stall
        drive(0, 1, 1, 1, 32'h14, 32'h11111111);
        chk_a("flush_stall", 32'h0, 32'h0, 0, 1, 5, 1);
        chk_b("flush_stall", 32'h0, 32'h0, 0, 3, 1);

        // Stall during squash holds the counter
        drive(0, 1, 0, 1, 32'h18, 32'h44444444);
        chk_a("sq_stall", 32'h0, 32'h0, 0, 1, 6, 1);
        chk_b("sq_stall", 32'h0, 32'h0, 0, 3, 1);

        // First unstalled load after flush: squashed on depth 2, passes on depth 1
        drive(0, 0, 0, 1, 32'h18, 32'h22222222);
        chk_a("squash", 32'h0, 32'h0, 0, 0, 6, 1);
        chk_b("squash", 32'h18, 32'h22222222, 1, 3, 1);

        drive(0, 0, 0, 1, 32'h1C, 32'h33333333);
        chk_a("post_sq", 32'h1C, 32'h33333333, 1, 0, 6, 1);
        chk_b("post_sq", 32'h1C, 32'h33333333, 1, 3, 1);

        // Back-to-back flushes reload rather than accumulate
        drive(0, 0, 1, 1, 32'h20, 32'h55555555);
        chk_a("flush2", 32'h0, 32'h0, 0, 1, 6, 2);
        chk_b("flush2", 32'h0, 32'h0, 0, 3, 2);
        drive(0, 0, 1, 1, 32'h24, 32'h66666666);
        chk_a("flush3", 32'h0, 32'h0, 0, 1, 6, 3);
        chk_b("flush3", 32'h0, 32'h0, 0, 3, 3);
        drive(0, 0, 0, 1, 32'h28, 32'h77777777);
        chk_a("sq_once", 32'h0, 32'h0, 0, 0, 6, 3);
        chk_b("sq_once", 32'h28, 32'h77777777, 1, 3, 3);
        drive(0, 0, 0, 1, 32'h2C, 32'h88888888);
        chk_a("no_accum", 32'h2C, 32'h88888888, 1, 0, 6, 3);
        chk_b("no_accum", 32'h2C, 32'h88888888, 1, 3, 3);

        // Flush counter saturates on the 2-bit instance
        drive(0, 0, 1, 1, 32'h30, 32'h99999999);
        chk_a("flush4", 32'h0, 32'h0, 0, 1, 6, 4);
        chk_b("flush4", 32'h0, 32'h0, 0, 3, 3);

        // Reset mid-squash clears the counter
        drive(1, 0, 0, 1, 32'h34, 32'hAAAAAAAA);
        chk_a("reset_sq", 32'h0, 32'h0, 0, 0, 0, 0);
        chk_b("reset_sq", 32'h0, 32'h0, 0, 0, 0);
        drive(0, 0, 0, 1, 32'h38, 32'hBBBBBBBB);
        chk_a("after_rst", 32'h38, 32'hBBBBBBBB, 1, 0, 0, 0);
        chk_b("after_rst", 32'h38, 32'hBBBBBBBB, 1, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
